limb_carry_resolve: RTL and testbench



---
 rtl/limb_carry_resolve.sv | 144 ++++++++++++++
 tb/tb_limb_carry_resolve.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/limb_carry_resolve.sv
// Serial carry resolver: folds N+4-bit redundant column sums into normalised N-bit limbs.
// Optional macro LIMB_RESOLVE_FLUSH_EN appends one extra limb per frame holding the final carry.
module limb_carry_resolve #(
    parameter int N         = 17,
    parameter int NUM_LIMBS = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         col_valid,
    output logic         col_ready,
    input  logic [N+3:0] col_sum,
    input  logic         col_last,
    output logic         limb_valid,
    input  logic         limb_ready,
    output logic [N-1:0] limb_data,
    output logic         limb_last,
    output logic [3:0]   carry_out,
    output logic         frame_err,
    input  logic         err_clr
);
    localparam int IDX_W = $clog2(NUM_LIMBS) + 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_LIMBS - 1);

`ifdef LIMB_RESOLVE_FLUSH_EN
    // state | meaning
    // ACCUM | accepting columns, one limb per accepted column
    // FLUSH | column input held off while the final carry is emitted as its own limb
    typedef enum logic {ACCUM, FLUSH} state_t;
    state_t state_q, state_d;
`endif

    logic [3:0]       carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             limb_valid_q, limb_valid_d;
    logic [N-1:0]     limb_data_q, limb_data_d;
    logic             limb_last_q, limb_last_d;
    logic [3:0]       carry_out_q, carry_out_d;
    logic             frame_err_q, frame_err_d;

    logic [N+4:0]     t;
    logic [3:0]       c_next;
    logic             out_free;
    logic             accept;
    logic             err_set;
    logic             unused_t_msb;

    assign out_free = !limb_valid_q || limb_ready;
    // reset_n gating keeps col_ready low while the block is held in reset
`ifdef LIMB_RESOLVE_FLUSH_EN
    assign col_ready = reset_n && (state_q == ACCUM) && out_free;
`else
    assign col_ready = reset_n && out_free;
`endif
    assign accept = col_valid && col_ready;

    // MSB of t can never be set: col_sum <= 13*(2^N-1) and carry <= 12
    assign t            = {1'b0, col_sum} + {{(N+1){1'b0}}, carry_q};
    assign c_next       = t[N+3:N];
    assign unused_t_msb = t[N+4];

    always_comb begin
        carry_d      = carry_q;
        idx_d        = idx_q;
        err_set      = 1'b0;
        limb_valid_d = limb_valid_q && !limb_ready;
        limb_data_d  = limb_data_q;
        limb_last_d  = limb_last_q;
        carry_out_d  = carry_out_q;
`ifdef LIMB_RESOLVE_FLUSH_EN
        state_d      = state_q;
`endif
        if (accept) begin
            limb_valid_d = 1'b1;
            limb_data_d  = t[N-1:0];
            limb_last_d  = 1'b0;
            carry_out_d  = 4'd0;
            if (col_last) begin
                err_set = (idx_q != IDX_MAX);
                idx_d   = '0;
`ifdef LIMB_RESOLVE_FLUSH_EN
                carry_d = c_next;
                state_d = FLUSH;
`else
                limb_last_d = 1'b1;
                carry_out_d = c_next;
                carry_d     = 4'd0;
`endif
            end else if (idx_q == IDX_MAX) begin
                // overrun: frame ends silently, no limb_last
                err_set = 1'b1;
                idx_d   = '0;
                carry_d = 4'd0;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                carry_d = c_next;
            end
        end
`ifdef LIMB_RESOLVE_FLUSH_EN
        else if (state_q == FLUSH && out_free) begin
            limb_valid_d = 1'b1;
            limb_data_d  = {{(N-4){1'b0}}, carry_q};
            limb_last_d  = 1'b1;
            carry_out_d  = 4'd0;
            carry_d      = 4'd0;
            state_d      = ACCUM;
        end
`endif
        if (err_set)      frame_err_d = 1'b1;
        else if (err_clr) frame_err_d = 1'b0;
        else              frame_err_d = frame_err_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            carry_q      <= 4'd0;
            idx_q        <= '0;
            limb_valid_q <= 1'b0;
            limb_data_q  <= '0;
            limb_last_q  <= 1'b0;
            carry_out_q  <= 4'd0;
            frame_err_q  <= 1'b0;
`ifdef LIMB_RESOLVE_FLUSH_EN
            state_q      <= ACCUM;
`endif
        end else begin
            carry_q      <= carry_d;
            idx_q        <= idx_d;
            limb_valid_q <= limb_valid_d;
            limb_data_q  <= limb_data_d;
            limb_last_q  <= limb_last_d;
            carry_out_q  <= carry_out_d;
            frame_err_q  <= frame_err_d;
`ifdef LIMB_RESOLVE_FLUSH_EN
            state_q      <= state_d;
`endif
        end
    end

    assign limb_valid = limb_valid_q;
    assign limb_data  = limb_data_q;
    assign limb_last  = limb_last_q;
    assign carry_out  = carry_out_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_limb_carry_resolve.sv
// Directed self-checking bench for limb_carry_resolve (N=17, NUM_LIMBS=8).
module tb_limb_carry_resolve;
    localparam int N = 17;
    localparam logic [N+3:0] MAXCOL = 21'd1703923;  // 13 * (2^17 - 1)

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         col_valid = 1'b0;
    logic         col_last = 1'b0;
    logic [N+3:0] col_sum = '0;
    logic         limb_ready = 1'b1;
    logic         err_clr = 1'b0;
    logic         col_ready, limb_valid, limb_last, frame_err;
    logic [N-1:0] limb_data;
    logic [3:0]   carry_out;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    limb_carry_resolve #(.N(N), .NUM_LIMBS(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .col_valid(col_valid), .col_ready(col_ready), .col_sum(col_sum), .col_last(col_last),
        .limb_valid(limb_valid), .limb_ready(limb_ready), .limb_data(limb_data),
        .limb_last(limb_last), .carry_out(carry_out),
        .frame_err(frame_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] data;
        logic         last;
        logic [3:0]   carry;
    } beat_t;
    beat_t beats[$];

    always @(posedge clk) begin
        if (limb_valid && limb_ready) beats.push_back({limb_data, limb_last, carry_out});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cols(input int n, input int flen, input logic [N+3:0] val);
        int sent = 0;
        int guard = 0;
        col_valid = 1'b1;
        col_sum   = val;
        while (sent < n && guard < 200) begin
            col_last = ((sent + 1) % flen == 0);
            #1;
            if (col_ready) sent++;
            @(posedge clk);
            #1;
            guard++;
        end
        col_valid = 1'b0;
        col_last  = 1'b0;
        chk("send_count", sent, n);
    endtask

    task automatic drain();
        int guard = 0;
        limb_ready = 1'b1;
        while (limb_valid && guard < 20) begin
            cyc();
            guard++;
        end
        chk("drain_idle", limb_valid, 0);
        cyc();
    endtask

    // Pops one frame from the beat queue; d0 = first limb, dr = remaining limbs, c = final carry
    task automatic check_frame(input string tag, input logic [N-1:0] d0, input logic [N-1:0] dr,
                               input logic [3:0] c);
        int    exp_n;
        beat_t b;
        logic [N-1:0] ed;
        logic         el;
        logic [3:0]   ec;
`ifdef LIMB_RESOLVE_FLUSH_EN
        exp_n = 9;
`else
        exp_n = 8;
`endif
        chk({tag, "_avail"}, (beats.size() >= exp_n), 1);
        for (int i = 0; i < exp_n; i++) begin
            if (beats.size() == 0) break;
            b  = beats.pop_front();
            ed = (i == 0) ? d0 : dr;
            el = 1'b0;
            ec = 4'd0;
`ifdef LIMB_RESOLVE_FLUSH_EN
            if (i == 8) begin
                ed = {{(N-4){1'b0}}, c};
                el = 1'b1;
            end
`else
            if (i == 7) begin
                el = 1'b1;
                ec = c;
            end
`endif
            chk($sformatf("%s_data%0d", tag, i), b.data, ed);
            chk($sformatf("%s_last%0d", tag, i), b.last, el);
            chk($sformatf("%s_carry%0d", tag, i), b.carry, ec);
        end
    endtask

    initial begin
        logic [N-1:0] held = '0;
        int sent;
        int ci;
        beat_t b;

        // reset state
        #1;
        chk("rst_col_ready", col_ready, 0);
        chk("rst_limb_valid", limb_valid, 0);
        chk("rst_limb_data", limb_data, 0);
        chk("rst_limb_last", limb_last, 0);
        chk("rst_carry_out", carry_out, 0);
        chk("rst_frame_err", frame_err, 0);
        cyc(2);
        reset_n = 1'b1;
        cyc();
        chk("post_rst_col_ready", col_ready, 1);

        // maximum columns
        send_cols(8, 8, MAXCOL);
        drain();
        check_frame("max", 17'h1FFF3, 17'h1FFFF, 4'd12);
        chk("max_err", frame_err, 0);

        // zero frame
        send_cols(8, 8, '0);
        drain();
        check_frame("zero", '0, '0, 4'd0);
        chk("zero_err", frame_err, 0);

        // backpressure: limb_ready low for cycles 3..5
        beats.delete();
        col_valid = 1'b1;
        col_sum   = MAXCOL;
        sent      = 0;
        ci        = 0;
        while (sent < 8 && ci < 60) begin
            limb_ready = !(ci >= 3 && ci < 6);
            col_last   = (sent == 7);
            #1;
            if (!limb_ready) begin
                chk("bp_col_ready", col_ready, 0);
                chk("bp_valid", limb_valid, 1);
                if (ci == 3) held = limb_data;
                else chk("bp_hold", limb_data, held);
            end
            if (col_ready) sent++;
            @(posedge clk);
            #1;
            ci++;
        end
        col_valid = 1'b0;
        col_last  = 1'b0;
        chk("bp_sent", sent, 8);
        drain();
        check_frame("bp", 17'h1FFF3, 17'h1FFFF, 4'd12);

        // short frame: col_last on 5th column
        beats.delete();
        send_cols(5, 5, MAXCOL);
        chk("short_err_set", frame_err, 1);
        drain();
        chk("short_err_sticky", frame_err, 1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("short_err_clr", frame_err, 0);
        beats.delete();

        // overrun: eight columns with no col_last
        send_cols(8, 100, MAXCOL);
        chk("ovr_err", frame_err, 1);
        drain();
        chk("ovr_n", beats.size(), 8);
        while (beats.size() > 0) begin
            b = beats.pop_front();
            chk("ovr_no_last", b.last, 0);
        end
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("ovr_err_clr", frame_err, 0);

        // back-to-back frames, no idle between them
        send_cols(16, 8, MAXCOL);
        drain();
        check_frame("b2b_f1", 17'h1FFF3, 17'h1FFFF, 4'd12);
        check_frame("b2b_f2", 17'h1FFF3, 17'h1FFFF, 4'd12);
        chk("b2b_err", frame_err, 0);

        // reset mid-frame after 3 columns
        beats.delete();
        send_cols(3, 100, MAXCOL);
        chk("rmf_valid_pre", limb_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmf_valid_drop", limb_valid, 0);
        chk("rmf_col_ready", col_ready, 0);
        cyc(2);
        reset_n = 1'b1;
        cyc();
        beats.delete();
        send_cols(8, 8, MAXCOL);
        drain();
        check_frame("rmf", 17'h1FFF3, 17'h1FFFF, 4'd12);
        chk("rmf_extra", beats.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
